bus_arbiter_mux: RTL and testbench

//  Parametrised, registered datapath bus for the CPU: N_SRC sources drive one WIDTH-bit bus

---
 rtl/bus_arbiter_mux.sv | 141 ++++++++++++++
 tb/tb_bus_arbiter_mux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// Registered multi-source datapath bus: fixed-priority grant, lock-based ownership and
// conflict tracking. Define BUS_PARITY_EN to add the registered even-parity output.
module bus_arbiter_mux #(
    parameter int unsigned N_SRC     = 24,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned HOLD_LAST = 1
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_out,
    input  logic                   bus_lock,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       bus_data,
    output logic                   bus_valid,
    output logic [SEL_W-1:0]       bus_sel,
    output logic                   conflict,
    output logic                   conflict_err,
    output logic [CNT_W-1:0]       conflict_cnt
`ifdef BUS_PARITY_EN
    ,
    output logic                   bus_parity
`endif
);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   data_d;
    logic               valid_d;
    logic [SEL_W-1:0]   sel_d;
    logic               hit;
    logic               err_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [SEL_W-1:0]   winner;
    logic               any_req;
    logic               multi_req;
    logic [N_SRC-1:0]   owner_mask;
    logic               owner_req;
    logic               other_req;
    logic [WIDTH-1:0]   src_arr [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
    end

    // Lowest set index wins; scanning downwards lets the lowest overwrite the others.
    always_comb begin
        winner = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (src_out[i]) winner = SEL_W'(i);
        end
    end

    assign any_req    = |src_out;
    assign multi_req  = |(src_out & (src_out - N_SRC'(1)));
    assign owner_mask = N_SRC'(1) << owner_q;
    assign owner_req  = |(src_out & owner_mask);
    assign other_req  = |(src_out & ~owner_mask);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        data_d  = (HOLD_LAST != 0) ? bus_data : '0;
        valid_d = 1'b0;
        sel_d   = bus_sel;
        hit     = 1'b0;
        if (state_q == StOwned && bus_lock && owner_req) begin
            data_d  = src_arr[owner_q];
            valid_d = 1'b1;
            sel_d   = owner_q;
            hit     = other_req;
        end else begin
            // Exit from ownership is resolved on the same edge with the idle rules.
            state_d = StIdle;
            hit     = multi_req;
            if (any_req) begin
                data_d  = src_arr[winner];
                sel_d   = winner;
                valid_d = 1'b1;
                if (bus_lock) begin
                    state_d = StOwned;
                    owner_d = winner;
                end
            end
        end
    end

    // A conflict in the same cycle as err_clr wins over the clear.
    always_comb begin
        err_d = conflict_err;
        cnt_d = conflict_cnt;
        if (hit) begin
            err_d = 1'b1;
            if (err_clr) begin
                cnt_d = CNT_W'(1);
            end else if (conflict_cnt != {CNT_W{1'b1}}) begin
                cnt_d = conflict_cnt + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            bus_data     <= '0;
            bus_valid    <= 1'b0;
            bus_sel      <= '0;
            conflict     <= 1'b0;
            conflict_err <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            bus_data     <= data_d;
            bus_valid    <= valid_d;
            bus_sel      <= sel_d;
            conflict     <= hit;
            conflict_err <= err_d;
            conflict_cnt <= cnt_d;
        end
    end

`ifdef BUS_PARITY_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            bus_parity <= 1'b0;
        end else begin
            bus_parity <= ^data_d;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: one HOLD_LAST=1 and one HOLD_LAST=0 instance on
// shared stimulus, checked with immediate assertions against hand-computed values.
module tb_bus_arbiter_mux;

    localparam int unsigned N = 24;
    localparam int unsigned W = 32;
    localparam int unsigned S = 5;
    localparam int unsigned C = 8;

    logic             clk = 1'b0;
    logic             clear_n;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     src_out;
    logic             bus_lock;
    logic             err_clr;

    logic [W-1:0]     a_data,  b_data;
    logic             a_valid, b_valid;
    logic [S-1:0]     a_sel,   b_sel;
    logic             a_conf,  b_conf;
    logic             a_err,   b_err;
    logic [C-1:0]     a_cnt,   b_cnt;
`ifdef BUS_PARITY_EN
    logic             a_par,   b_par;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_arbiter_mux #(.N_SRC(N), .WIDTH(W), .SEL_W(S), .CNT_W(C), .HOLD_LAST(1)) u_hold (
        .clk(clk), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
        .bus_lock(bus_lock), .err_clr(err_clr), .bus_data(a_data), .bus_valid(a_valid),
        .bus_sel(a_sel), .conflict(a_conf), .conflict_err(a_err), .conflict_cnt(a_cnt)
`ifdef BUS_PARITY_EN
        , .bus_parity(a_par)
`endif
    );

    bus_arbiter_mux #(.N_SRC(N), .WIDTH(W), .SEL_W(S), .CNT_W(C), .HOLD_LAST(0)) u_clr (
        .clk(clk), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
        .bus_lock(bus_lock), .err_clr(err_clr), .bus_data(b_data), .bus_valid(b_valid),
        .bus_sel(b_sel), .conflict(b_conf), .conflict_err(b_err), .conflict_cnt(b_cnt)
`ifdef BUS_PARITY_EN
        , .bus_parity(b_par)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_n  = 1'b0;
        src_data = '0;
        src_out  = '0;
        bus_lock = 1'b0;
        err_clr  = 1'b0;
        #12;
        chk("rst_data",  a_data, 32'h0);
        chk("rst_valid", {31'b0, a_valid}, 32'h0);
        chk("rst_sel",   {27'b0, a_sel}, 32'h0);
        chk("rst_conf",  {31'b0, a_conf}, 32'h0);
        chk("rst_err",   {31'b0, a_err}, 32'h0);
        chk("rst_cnt",   {24'b0, a_cnt}, 32'h0);
        clear_n = 1'b1;

        // Single MDR source, then idle hold / idle clear.
        src_data[21*W +: W] = 32'hDEAD_BEEF;
        src_out = 24'h1 << 21;
        tick();
        chk("t1_data",  a_data, 32'hDEAD_BEEF);
        chk("t1_sel",   {27'b0, a_sel}, 32'd21);
        chk("t1_valid", {31'b0, a_valid}, 32'h1);
        chk("t1_conf",  {31'b0, a_conf}, 32'h0);
        src_out = '0;
        tick();
        chk("t1_hold_data",  a_data, 32'hDEAD_BEEF);
        chk("t1_hold_valid", {31'b0, a_valid}, 32'h0);
        chk("t1_hold_sel",   {27'b0, a_sel}, 32'd21);
        chk("t1_clr_data",   b_data, 32'h0);
        chk("t1_clr_valid",  {31'b0, b_valid}, 32'h0);

        // Two requesters: lowest index wins, conflict recorded.
        src_data[3*W +: W]  = 32'h3;
        src_data[19*W +: W] = 32'h19;
        src_out = (24'h1 << 3) | (24'h1 << 19);
        tick();
        chk("t2_data", a_data, 32'h3);
        chk("t2_sel",  {27'b0, a_sel}, 32'd3);
        chk("t2_conf", {31'b0, a_conf}, 32'h1);
        chk("t2_err",  {31'b0, a_err}, 32'h1);
        chk("t2_cnt",  {24'b0, a_cnt}, 32'h1);
        src_out = '0;
        tick();
        chk("t2_pulse_end", {31'b0, a_conf}, 32'h0);
        chk("t2_err_sticky", {31'b0, a_err}, 32'h1);
        chk("t2_cnt_hold",  {24'b0, a_cnt}, 32'h1);

        // Locked ownership by source 20 ignores a lower-index requester.
        src_data[20*W +: W] = 32'h20;
        src_data[2*W +: W]  = 32'h2;
        src_out  = 24'h1 << 20;
        bus_lock = 1'b1;
        tick();
        chk("t3_grant_sel",  {27'b0, a_sel}, 32'd20);
        chk("t3_grant_conf", {31'b0, a_conf}, 32'h0);
        src_out = (24'h1 << 20) | (24'h1 << 2);
        tick();
        chk("t3_own_sel",  {27'b0, a_sel}, 32'd20);
        chk("t3_own_data", a_data, 32'h20);
        chk("t3_own_conf", {31'b0, a_conf}, 32'h1);
        chk("t3_own_cnt",  {24'b0, a_cnt}, 32'h2);
        bus_lock = 1'b0;
        src_out  = 24'h1 << 2;
        tick();
        chk("t3_exit_sel",  {27'b0, a_sel}, 32'd2);
        chk("t3_exit_data", a_data, 32'h2);
        chk("t3_exit_conf", {31'b0, a_conf}, 32'h0);

        // Counter saturation and err_clr priority.
        src_out = '0;
        err_clr = 1'b1;
        tick();
        chk("t4_clr_cnt", {24'b0, a_cnt}, 32'h0);
        chk("t4_clr_err", {31'b0, a_err}, 32'h0);
        err_clr = 1'b0;
        src_out = 24'h3;
        repeat (254) tick();
        chk("t4_cnt_254", {24'b0, a_cnt}, 32'd254);
        repeat (46) tick();
        chk("t4_cnt_sat", {24'b0, a_cnt}, 32'd255);
        tick();
        chk("t4_cnt_stay", {24'b0, a_cnt}, 32'd255);
        src_out = '0;
        err_clr = 1'b1;
        tick();
        chk("t4_clr2_cnt", {24'b0, a_cnt}, 32'h0);
        chk("t4_clr2_err", {31'b0, a_err}, 32'h0);
        src_out = 24'h3;
        tick();
        chk("t4_win_cnt", {24'b0, a_cnt}, 32'h1);
        chk("t4_win_err", {31'b0, a_err}, 32'h1);
        err_clr = 1'b0;
        src_out = '0;
        tick();

        // Asynchronous reset while owned, then fresh idle arbitration.
        src_out  = 24'h1 << 20;
        bus_lock = 1'b1;
        tick();
        chk("t5_own_sel", {27'b0, a_sel}, 32'd20);
        clear_n = 1'b0;
        #1;
        chk("t5_rst_data",  a_data, 32'h0);
        chk("t5_rst_valid", {31'b0, a_valid}, 32'h0);
        chk("t5_rst_sel",   {27'b0, a_sel}, 32'h0);
        chk("t5_rst_err",   {31'b0, a_err}, 32'h0);
        chk("t5_rst_cnt",   {24'b0, a_cnt}, 32'h0);
        src_data[5*W +: W] = 32'h55;
        src_out  = (24'h1 << 20) | (24'h1 << 5);
        bus_lock = 1'b0;
        #1;
        clear_n = 1'b1;
        tick();
        chk("t5_regrant_sel",  {27'b0, a_sel}, 32'd5);
        chk("t5_regrant_data", a_data, 32'h55);
        chk("t5_regrant_conf", {31'b0, a_conf}, 32'h1);
        src_out = '0;
        tick();
        chk("t5_idle_hold", a_data, 32'h55);
        chk("t5_idle_clr",  b_data, 32'h0);

`ifdef BUS_PARITY_EN
        src_data[0 +: W] = 32'h7;
        src_out = 24'h1;
        tick();
        chk("t6_par_odd", {31'b0, a_par}, 32'h1);
        src_data[0 +: W] = 32'h3;
        tick();
        chk("t6_par_even", {31'b0, a_par}, 32'h0);
        src_data[0 +: W] = 32'h7;
        tick();
        src_out = '0;
        tick();
        chk("t6_par_held", {31'b0, a_par}, 32'h1);
        chk("t6_par_clr",  {31'b0, b_par}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
